// File: rtl/load_store_unit_if.sv
// Request/response and memory-side signal bundle for the load/store unit.
// The slave modport is the unit's view; the master modport is the
// requester/memory-model view.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [7:0]            err_count;

  logic                  mem_r_en;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_byte_en;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, err_count,
           mem_r_en, mem_wr_en, mem_addr, mem_wdata, mem_byte_en
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, err_count,
           mem_r_en, mem_wr_en, mem_addr, mem_wdata, mem_byte_en
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one request at a time, checks the width
// code and alignment, performs a single word-aligned memory access with
// byte enables, and returns sign/zero-extended load data or an error.
// Flow: IDLE -> ACCESS -> (WAIT for loads) -> RESP -> IDLE; bad requests
// go straight IDLE -> RESP without touching memory.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                state_r;
  logic                  we_r;
  logic [2:0]            funct3_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;

  logic                  rsp_valid_r;
  logic [DATA_WIDTH-1:0] rsp_rdata_r;
  logic                  rsp_err_r;
  logic [7:0]            err_count_r;

  logic                  mem_r_en_r;
  logic                  mem_wr_en_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic [3:0]            mem_byte_en_r;

  // Width code is legal for the given direction (stores have no unsigned forms).
  function automatic logic is_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (we) begin
      case (f3)
        3'b000, 3'b001, 3'b010: ok = 1'b1;
        default:                ok = 1'b0;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
        default:                                ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = a[0];
      2'b10:   mis = (a != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Byte lanes touched by an access of size f3[1:0] at offset a.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] m;
    case (size)
      2'b00: begin
        case (a)
          2'b00:   m = 4'b0001;
          2'b01:   m = 4'b0010;
          2'b10:   m = 4'b0100;
          default: m = 4'b1000;
        endcase
      end
      2'b01:   m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Store data replicated across all lanes so the byte enables pick the right one.
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] w);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{w[7:0]}};
      2'b01:   d = {2{w[15:0]}};
      default: d = w;
    endcase
    return d;
  endfunction

  // Select the addressed lane from the memory word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Transaction FSM with registered response and memory-strobe outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      we_r          <= 1'b0;
      funct3_r      <= 3'd0;
      addr_r        <= '0;
      wdata_r       <= '0;
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= '0;
      rsp_err_r     <= 1'b0;
      err_count_r   <= 8'd0;
      mem_r_en_r    <= 1'b0;
      mem_wr_en_r   <= 1'b0;
      mem_addr_r    <= '0;
      mem_wdata_r   <= '0;
      mem_byte_en_r <= 4'b0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            we_r     <= bus.req_we;
            funct3_r <= bus.req_funct3;
            addr_r   <= bus.req_addr;
            wdata_r  <= bus.req_wdata;
            if (!is_legal(bus.req_we, bus.req_funct3) ||
                is_misaligned(bus.req_funct3, bus.req_addr[1:0])) begin
              // Bad request: answer immediately, never strobe memory.
              state_r     <= RESP;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
              rsp_rdata_r <= '0;
              if (err_count_r != 8'hFF) begin
                err_count_r <= err_count_r + 8'd1;
              end
            end else begin
              state_r       <= ACCESS;
              mem_addr_r    <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_byte_en_r <= lane_mask(bus.req_funct3[1:0], bus.req_addr[1:0]);
              if (bus.req_we) begin
                mem_wr_en_r <= 1'b1;
                mem_wdata_r <= store_data(bus.req_funct3[1:0], bus.req_wdata);
              end else begin
                mem_r_en_r  <= 1'b1;
              end
            end
          end
        end
        ACCESS: begin
          // Strobes last exactly one cycle.
          mem_r_en_r    <= 1'b0;
          mem_wr_en_r   <= 1'b0;
          mem_byte_en_r <= 4'b0000;
          if (we_r) begin
            state_r     <= RESP;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= '0;
          end else begin
            state_r <= WAIT;
          end
        end
        WAIT: begin
          // Memory read data is valid this cycle, one after the read strobe.
          state_r     <= RESP;
          rsp_valid_r <= 1'b1;
          rsp_err_r   <= 1'b0;
          rsp_rdata_r <= load_extract(funct3_r, addr_r[1:0], bus.mem_rdata);
        end
        RESP: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
          rsp_err_r   <= 1'b0;
          rsp_rdata_r <= '0;
        end
        default: begin
          state_r       <= IDLE;
          rsp_valid_r   <= 1'b0;
          rsp_err_r     <= 1'b0;
          rsp_rdata_r   <= '0;
          mem_r_en_r    <= 1'b0;
          mem_wr_en_r   <= 1'b0;
          mem_byte_en_r <= 4'b0000;
        end
      endcase
    end
  end

  // Store data is latched for completeness; only the replicated copy drives memory.
  logic unused_wdata;
  assign unused_wdata = ^wdata_r;

  assign bus.req_ready   = (state_r == IDLE);
  assign bus.rsp_valid   = rsp_valid_r;
  assign bus.rsp_rdata   = rsp_rdata_r;
  assign bus.rsp_err     = rsp_err_r;
  assign bus.err_count   = err_count_r;
  assign bus.mem_r_en    = mem_r_en_r;
  assign bus.mem_wr_en   = mem_wr_en_r;
  assign bus.mem_addr    = mem_addr_r;
  assign bus.mem_wdata   = mem_wdata_r;
  assign bus.mem_byte_en = mem_byte_en_r;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; only 32 supported.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  unit accepts request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  RV32I width code.
REQ-009 SHALL have port req_addr  input  ADDR_WIDTH  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port rsp_err  output  1  misaligned or illegal request, qualified by rsp_valid.
REQ-014 SHALL have port err_count  output  8  saturating count of error responses.
REQ-015 SHALL have ports mem_r_en  output  1, mem_wr_en  output  1, mem_addr  output  ADDR_WIDTH (bits [1:0] always 0), mem_wdata  output  32, mem_byte_en  output  4, mem_rdata  input  32 (valid the cycle after mem_r_en).

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, WAIT, RESP; req_ready = (state == IDLE).
REQ-017 SHALL accept on req_valid && req_ready, registering we, funct3, addr, wdata.
REQ-018 Legal codes SHALL be: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; all others illegal.
REQ-019 Misaligned SHALL mean halfword with addr[0]=1, or word with addr[1:0]!=0.
REQ-020 Illegal or misaligned accept SHALL go IDLE -> RESP with no memory strobe; rsp_err=1, rsp_rdata=0.
REQ-021 Legal accept SHALL go IDLE -> ACCESS; in ACCESS exactly one of mem_r_en/mem_wr_en is 1 for one cycle, mem_addr = {addr[31:2],2'b00}.
REQ-022 Store SHALL go ACCESS -> RESP; load SHALL go ACCESS -> WAIT -> RESP, capturing mem_rdata in WAIT.
REQ-023 RESP SHALL assert rsp_valid for one cycle then return to IDLE; no backpressure on response.
REQ-024 Latency from accept edge to rsp_valid: store 2 cycles, load 3 cycles, error 1 cycle.
REQ-025 Store lanes: SB byte replicated x4, byte_en = 1 << addr[1:0]; SH halfword replicated x2, byte_en = 0011 (addr[1]=0) or 1100; SW byte_en = 1111.
REQ-026 Load extraction SHALL select byte lane addr[1:0] or halfword lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-027 mem_r_en, mem_wr_en, mem_byte_en SHALL be 0 outside ACCESS; mem_addr/mem_wdata hold last value.
REQ-028 err_count SHALL increment once per error response, saturating at 255.
REQ-029 req_valid during non-IDLE states SHALL be ignored and not latched.

Reset
REQ-030 rst high at an edge SHALL force state IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, err_count=0, all mem_* outputs 0 from that edge.
REQ-031 rst in ACCESS, WAIT or RESP SHALL abort the transaction with no response; a write strobe already driven that cycle is not retracted.
REQ-032 rst SHALL take priority over simultaneous req_valid; req_ready is 1 the cycle after reset.

Verification
REQ-033 SW addr 0x0000_0010 wdata 0xDEADBEEF -> ACCESS: mem_wr_en=1, mem_addr 0x10, byte_en 1111; rsp_valid 2 cycles after accept, rsp_err=0.
REQ-034 LB addr 0x13, mem_rdata 0x80AB_CDEF -> rsp_rdata 0xFFFF_FF80; LBU same -> 0x0000_0080; latency 3.
REQ-035 SH addr 0x22 wdata 0x0000_1234 -> mem_addr 0x20, mem_wdata 0x1234_1234, byte_en 1100; LH addr 0x22 with mem_rdata 0x8001_0000 -> 0xFFFF_8001.
REQ-036 LW addr 0x5 -> no mem strobe, rsp_valid next cycle, rsp_err=1, rsp_rdata 0, err_count 1; 300 errors -> err_count 255.
REQ-037 Load accepted then rst asserted in WAIT -> no rsp_valid, req_ready=1 next cycle, err_count 0.
REQ-038 req_valid held high across back-to-back loads -> second accept only in IDLE, one response per accept.
